bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, which sets the binary input width in bits (range 4..64).
REQ-002 SHALL have parameter DIGITS, default 10, which sets the number of 4-bit BCD digits produced (range 1..20).
REQ-003 SHALL have input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have input rst_n, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have input in_valid, 1 bit: bin_in is valid.
REQ-006 SHALL have output in_ready, 1 bit: the block can accept a value.
REQ-007 SHALL have input bin_in, WIDTH bits: the value to convert.
REQ-008 SHALL have output out_valid, 1 bit: a result is available.
REQ-009 SHALL have input out_ready, 1 bit: the consumer takes the result.
REQ-010 SHALL have output bcd_out, 4*DIGITS bits: the BCD result, least significant digit in [3:0].
REQ-011 SHALL have output sign, 1 bit: the result is negative.
REQ-012 SHALL have output overflow, 1 bit: the magnitude is 10^DIGITS or more, so bcd_out is truncated to the low DIGITS digits.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-014 SHALL assert in_ready only in IDLE, and SHALL accept a value when in_valid && in_ready.
REQ-015 On accept, SHALL latch the magnitude of bin_in into the shift register, clear the BCD field and overflow, set the iteration counter to 0, latch sign, and enter SHIFT.
REQ-016 In SHIFT, SHALL perform one double-dabble iteration per cycle: add 3 to every digit that is >= 5, then shift {BCD field, magnitude} left by one bit.
REQ-017 SHALL set overflow (sticky) when the MSB of the top digit, after adjustment, is 1 before a shift.
REQ-018 After exactly WIDTH iterations, SHALL enter DONE and assert out_valid; out_valid therefore rises WIDTH cycles after the accept edge.
REQ-019 In DONE, SHALL hold bcd_out, sign and overflow stable until out_valid && out_ready, then return to IDLE.
REQ-020 SHALL give no same-cycle accept in DONE, so throughput is one conversion per WIDTH+2 cycles minimum.
REQ-021 SHALL ignore in_valid outside IDLE, with no side effects.
REQ-022 SHALL drive bcd_out, sign and overflow from registers; their values are don't-care when out_valid is 0, but SHALL be held from the last result.

Reset
REQ-023 While rst_n is 0, SHALL asynchronously force state to IDLE and out_valid, bcd_out, sign, overflow and the counter to 0; in_ready SHALL read 1.
REQ-024 Reset asserted during SHIFT or DONE SHALL discard the conversion in progress, with no output pulse after release.

Configuration
REQ-025 With macro BIN2BCD_SIGNED_EN defined, SHALL treat bin_in as two's complement: sign = bin_in[WIDTH-1] and magnitude = |bin_in|. The most negative value SHALL convert to 2^(WIDTH-1) as an unsigned WIDTH-bit magnitude.
REQ-026 Without BIN2BCD_SIGNED_EN, SHALL treat bin_in as unsigned, and sign SHALL be constant 0.

Structure
REQ-027 SHALL place the FSM state enum and a constant function min_digits(width) (returns ceil(width*log10 2)) in package bin2bcd_pkg.
REQ-028 SHALL contain one sub-module, bcd_digit_adj: a combinational 4-bit conditional add-3, instantiated DIGITS times.
REQ-029 SHALL raise an elaboration-time error for WIDTH or DIGITS out of range; DIGITS < min_digits(WIDTH) is legal and reports via overflow.

Verification (WIDTH=32, DIGITS=10 unless stated)
REQ-030 Unsigned build, bin_in=0xFFFFFFFF -> after 32 cycles, out_valid=1, bcd_out=0x4294967295, overflow=0, sign=0.
REQ-031 Signed build, bin_in=0xFFFFFFFF -> sign=1, bcd_out=0x0000000001; bin_in=0x80000000 -> sign=1, bcd_out=0x2147483648.
REQ-032 DIGITS=8, bin_in=123456789 -> bcd_out=0x23456789, overflow=1; then bin_in=99999999 -> overflow=0.
REQ-033 out_ready held 0 for 10 cycles in DONE, with in_valid=1 and a new bin_in -> in_ready=0, outputs unchanged, new value not accepted; out_ready=1 -> IDLE next cycle, then accept.
REQ-034 rst_n pulsed low at iteration 15 of a conversion -> all outputs 0 and in_ready=1 immediately; after release, no out_valid without a new accept.
REQ-035 Back-to-back random 1000 values with out_ready=1 -> every result matches a reference model, and each accept-to-out_valid latency is exactly 32 cycles.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared FSM encoding and sizing helpers for the sequential binary-to-BCD converter.
// The signed-input build of bin2bcd_seq is selected with macro BIN2BCD_SIGNED_EN.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // ceil(width * log10(2)); 0.30103 is close enough that no width in 1..64 rounds the wrong way.
    function automatic int min_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next decade.
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, valid/ready on both sides.
// Define BIN2BCD_SIGNED_EN to treat bin_in as two's complement and report the sign separately.
module bin2bcd_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign,
    output logic                  overflow
);
    import bin2bcd_pkg::*;

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("bin2bcd_seq: WIDTH must be in 4..64");
    end
    if (DIGITS < 1 || DIGITS > 20) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS must be in 1..20");
    end

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    mag_q, mag_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bcd_out_q, bcd_out_d;
    logic                ovf_out_q, ovf_out_d;
    logic [WIDTH-1:0]    mag_in;
    logic [BW-1:0]       bcd_adj;
    logic [BW+WIDTH-1:0] shifted;
`ifdef BIN2BCD_SIGNED_EN
    logic                sign_in;
    logic                sign_q, sign_d;
    logic                sign_out_q, sign_out_d;
`endif

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (bcd_q[4*gi +: 4]),
            .digit_o (bcd_adj[4*gi +: 4])
        );
    end

    assign shifted = {bcd_adj[BW-2:0], mag_q, 1'b0};

`ifdef BIN2BCD_SIGNED_EN
    // Negating the most negative value wraps back to 2^(WIDTH-1), which is its true magnitude.
    assign sign_in = bin_in[WIDTH-1];
    assign mag_in  = sign_in ? (~bin_in + WIDTH'(1)) : bin_in;
`else
    assign mag_in  = bin_in;
`endif

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        bcd_out_d = bcd_out_q;
        ovf_out_d = ovf_out_q;
`ifdef BIN2BCD_SIGNED_EN
        sign_d     = sign_q;
        sign_out_d = sign_out_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mag_d   = mag_in;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
`ifdef BIN2BCD_SIGNED_EN
                    sign_d  = sign_in;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A set MSB in the top adjusted digit is a decade carry that falls off the field.
                bcd_d = shifted[BW+WIDTH-1:WIDTH];
                mag_d = shifted[WIDTH-1:0];
                ovf_d = ovf_q | bcd_adj[BW-1];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    bcd_out_d  = shifted[BW+WIDTH-1:WIDTH];
                    ovf_out_d  = ovf_q | bcd_adj[BW-1];
`ifdef BIN2BCD_SIGNED_EN
                    sign_out_d = sign_q;
`endif
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mag_q      <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            bcd_out_q  <= '0;
            ovf_out_q  <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            sign_q     <= 1'b0;
            sign_out_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            bcd_out_q  <= bcd_out_d;
            ovf_out_q  <= ovf_out_d;
`ifdef BIN2BCD_SIGNED_EN
            sign_q     <= sign_d;
            sign_out_q <= sign_out_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd_out   = bcd_out_q;
    assign overflow  = ovf_out_q;
`ifdef BIN2BCD_SIGNED_EN
    assign sign      = sign_out_q;
`else
    assign sign      = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a 32-bit/10-digit instance and a 32-bit/8-digit instance.
// Expectations follow BIN2BCD_SIGNED_EN when the bench is compiled with it.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sign, a_overflow;
    logic [31:0] a_bin_in;
    logic [39:0] a_bcd_out;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sign, b_overflow;
    logic [31:0] b_bin_in;
    logic [31:0] b_bcd_out;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.WIDTH(32), .DIGITS(10)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .bin_in(a_bin_in),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .bcd_out(a_bcd_out), .sign(a_sign), .overflow(a_overflow)
    );

    bin2bcd_seq #(.WIDTH(32), .DIGITS(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .bin_in(b_bin_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .bcd_out(b_bcd_out), .sign(b_sign), .overflow(b_overflow)
    );

    // Reference conversion by repeated division, independent of the shift-and-add hardware.
    function automatic logic [39:0] ref_bcd(input logic [31:0] v, input int ndig,
                                            output logic ovf, output logic sgn);
        longint unsigned m;
        logic [39:0] r;
        r   = '0;
        sgn = 1'b0;
        m   = 64'(v);
`ifdef BIN2BCD_SIGNED_EN
        if (v[31]) begin
            sgn = 1'b1;
            m   = 64'h1_0000_0000 - 64'(v);
        end
`endif
        for (int i = 0; i < ndig; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        ovf = (m != 0);
        return r;
    endfunction

    // Presents one value and returns cycles from the accept edge to out_valid (-1 on timeout).
    task automatic convert(input bit use_b, input logic [31:0] value, output int lat);
        int n;
        n = 0;
        while (!(use_b ? b_in_ready : a_in_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (use_b) begin b_bin_in = value; b_in_valid = 1'b1; end
        else       begin a_bin_in = value; a_in_valid = 1'b1; end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        lat = -1;
        n = 0;
        while (lat < 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (use_b ? b_out_valid : a_out_valid) lat = n;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_bcd_out !== 40'h0 ||
            a_overflow !== 1'b0 || a_sign !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: rdy=%b vld=%b bcd=%h ovf=%b sign=%b, required 1 0 0 0 0",
                     a_in_ready, a_out_valid, a_bcd_out, a_overflow, a_sign);
        end
        checks++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_bcd_out !== 32'h0 || b_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: rdy=%b vld=%b bcd=%h ovf=%b, required 1 0 0 0",
                     b_in_ready, b_out_valid, b_bcd_out, b_overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: vld=%b rdy=%b, required 0 1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] dv [7];
        logic [39:0] db [7];
        logic        ds [7];
        int lat;
        dv[0] = 32'd0;          db[0] = 40'h0000000000; ds[0] = 1'b0;
        dv[1] = 32'd9;          db[1] = 40'h0000000009; ds[1] = 1'b0;
        dv[2] = 32'd10;         db[2] = 40'h0000000010; ds[2] = 1'b0;
        dv[3] = 32'd99;         db[3] = 40'h0000000099; ds[3] = 1'b0;
        dv[4] = 32'd1234567890; db[4] = 40'h1234567890; ds[4] = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
        dv[5] = 32'h80000000;   db[5] = 40'h2147483648; ds[5] = 1'b1;
        dv[6] = 32'hFFFFFFFF;   db[6] = 40'h0000000001; ds[6] = 1'b1;
`else
        dv[5] = 32'h80000000;   db[5] = 40'h2147483648; ds[5] = 1'b0;
        dv[6] = 32'hFFFFFFFF;   db[6] = 40'h4294967295; ds[6] = 1'b0;
`endif
        for (int i = 0; i < 7; i++) begin
            convert(1'b0, dv[i], lat);
            $display("xfer directed v=%h bcd=%h ovf=%b sign=%b lat=%0d", dv[i], a_bcd_out, a_overflow, a_sign, lat);
            checks++;
            if (lat != 32) begin
                errors++;
                $display("FAIL directed_latency v=%h: got %0d, required 32", dv[i], lat);
            end
            checks++;
            if (a_bcd_out !== db[i] || a_overflow !== 1'b0 || a_sign !== ds[i]) begin
                errors++;
                $display("FAIL directed_result v=%h: bcd=%h ovf=%b sign=%b, required %h 0 %b",
                         dv[i], a_bcd_out, a_overflow, a_sign, db[i], ds[i]);
            end
            a_out_ready = 1'b1;
            @(posedge clk); #1;
            a_out_ready = 1'b0;
            checks++;
            if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed_handshake v=%h: vld=%b rdy=%b, required 0 1", dv[i], a_out_valid, a_in_ready);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] dv [4];
        logic [31:0] db [4];
        logic        dov [4];
        int lat;
        dv[0] = 32'd123456789; db[0] = 32'h23456789; dov[0] = 1'b1;
        dv[1] = 32'd99999999;  db[1] = 32'h99999999; dov[1] = 1'b0;
        dv[2] = 32'd100000000; db[2] = 32'h00000000; dov[2] = 1'b1;
        dv[3] = 32'd5;         db[3] = 32'h00000005; dov[3] = 1'b0;
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            convert(1'b1, dv[i], lat);
            $display("xfer overflow v=%0d bcd=%h ovf=%b lat=%0d", dv[i], b_bcd_out, b_overflow, lat);
            checks++;
            if (lat != 32 || b_bcd_out !== db[i] || b_overflow !== dov[i]) begin
                errors++;
                $display("FAIL overflow_8dig v=%0d: bcd=%h ovf=%b lat=%0d, required %h %b 32",
                         dv[i], b_bcd_out, b_overflow, lat, db[i], dov[i]);
            end
        end
        @(posedge clk); #1;
        b_out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        int n;
        convert(1'b0, 32'd12345678, lat);
        $display("xfer backpressure v=12345678 bcd=%h lat=%0d", a_bcd_out, lat);
        checks++;
        if (lat != 32 || a_bcd_out !== 40'h0012345678) begin
            errors++;
            $display("FAIL bp_first: bcd=%h lat=%0d, required 0012345678 32", a_bcd_out, lat);
        end
        a_bin_in   = 32'd87654321;
        a_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_bcd_out !== 40'h0012345678) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: rdy=%b vld=%b bcd=%h, required 0 1 0012345678",
                         i, a_in_ready, a_out_valid, a_bcd_out);
            end
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: vld=%b rdy=%b, required 0 1", a_out_valid, a_in_ready);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: rdy=%b, required 0", a_in_ready);
        end
        lat = -1;
        n = 0;
        while (lat < 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (a_out_valid) lat = n;
        end
        $display("xfer backpressure v=87654321 bcd=%h lat=%0d", a_bcd_out, lat);
        checks++;
        if (lat != 32 || a_bcd_out !== 40'h0087654321) begin
            errors++;
            $display("FAIL bp_second: bcd=%h lat=%0d, required 0087654321 32", a_bcd_out, lat);
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        a_bin_in   = 32'h12345678;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_bcd_out !== 40'h0 ||
            a_overflow !== 1'b0 || a_sign !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b vld=%b bcd=%h ovf=%b sign=%b, required 1 0 0 0 0",
                     a_in_ready, a_out_valid, a_bcd_out, a_overflow, a_sign);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (a_out_valid) seen = 1'b1;
        end
        $display("xfer reset_mid v=12345678 aborted, out_valid seen after release=%b", seen);
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_pulse: out_valid seen=%b, required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        logic [39:0] exp_bcd;
        logic        exp_ovf, exp_sgn;
        int lat;
        a_out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            v = $urandom;
            if (i == 0) v = 32'hFFFFFFFF;
            if (i == 1) v = 32'h80000000;
            exp_bcd = ref_bcd(v, 10, exp_ovf, exp_sgn);
            convert(1'b0, v, lat);
            $display("xfer b2b %0d v=%h bcd=%h sign=%b lat=%0d", i, v, a_bcd_out, a_sign, lat);
            checks++;
            if (lat != 32) begin
                errors++;
                $display("FAIL b2b_latency v=%h: got %0d, required 32", v, lat);
            end
            checks++;
            if (a_bcd_out !== exp_bcd || a_overflow !== exp_ovf || a_sign !== exp_sgn) begin
                errors++;
                $display("FAIL b2b_result v=%h: bcd=%h ovf=%b sign=%b, required %h %b %b",
                         v, a_bcd_out, a_overflow, a_sign, exp_bcd, exp_ovf, exp_sgn);
            end
        end
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        a_in_valid  = 1'b0; a_out_ready = 1'b0; a_bin_in = '0;
        b_in_valid  = 1'b0; b_out_ready = 1'b0; b_bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
